// File: rtl/auto_player_pkg.sv
// Shared encodings for the auto-play sequencer: FSM states, play modes, ROM note width.
// Pure constants and helpers; no logic, no latency, no flow control.
package auto_player_pkg;

    localparam int NOTE_BITS     = 4;
    localparam int NUM_SONGS_DEF = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_ADVANCE = 3'd4;
    localparam logic [2:0] S_PAUSED  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] MODE_ONCE       = 2'd0;
    localparam logic [1:0] MODE_REPEAT_ONE = 2'd1;
    localparam logic [1:0] MODE_REPEAT_ALL = 2'd2;

    // Encoding 3 is reserved and behaves like a single pass.
    function automatic logic [1:0] mode_norm(input logic [1:0] m);
        return (m == 2'd3) ? MODE_ONCE : m;
    endfunction

endpackage

// File: rtl/auto_player_gap_timer.sv
// Pausable down-counter: load wins, run decrements, hold otherwise; expire_o pulses
// combinationally in the last running cycle (GAP lasts exactly load_val_i running clocks).
module auto_player_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (run_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    assign expire_o = run_i && !load_i && (cnt_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/auto_player.sv
// Auto-play sequencer: walks song ROM note by note, drives Sound via snd_en/snd_over, one-hot led.
// ROM read takes one FETCH cycle per note; pause freezes PLAY/GAP in place, en=0 aborts to IDLE.
module auto_player
    import auto_player_pkg::*;
#(
    parameter int NUM_SONGS     = NUM_SONGS_DEF,
    parameter int SONG_BITS     = 3,
    parameter int CNT_BITS      = 8,
    parameter int NOTE_KEY_BITS = 7,
    parameter int GAP_CYCLES    = 2500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [SONG_BITS-1:0]     song,
    input  logic [1:0]               mode,
    input  logic                     pause,
    input  logic                     skip_next,
    input  logic                     skip_prev,
    output logic [SONG_BITS-1:0]     rom_song,
    output logic [CNT_BITS-1:0]      rom_idx,
    input  logic [CNT_BITS-1:0]      rom_track,
    input  logic [NOTE_BITS-1:0]     rom_note,
    output logic                     snd_en,
    input  logic                     snd_over,
    output logic [NOTE_KEY_BITS-1:0] led,
    output logic                     playing,
    output logic                     done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [SONG_BITS-1:0] LAST_SONG  = SONG_BITS'(NUM_SONGS - 1);
    localparam logic [2:0]           OVER_STATE = (GAP_CYCLES == 0) ? S_ADVANCE : S_GAP;

    logic [2:0]           state_q, state_d;
    logic [2:0]           saved_q, saved_d;
    logic [SONG_BITS-1:0] song_q, song_d;
    logic [CNT_BITS-1:0]  idx_q, idx_d;
    logic [NOTE_BITS-1:0] note_q, note_d;

    logic                 skip, pausable, to_done;
    logic [SONG_BITS-1:0] skip_song;
    logic                 gap_load, gap_run, gap_expire;

    assign skip     = (skip_next || skip_prev) && (state_q != S_IDLE);
    assign pausable = pause && (state_q == S_PLAY || state_q == S_GAP || state_q == S_PAUSED);
    assign gap_load = en && !skip && (state_q == S_PLAY) && snd_over;
    assign gap_run  = en && !skip && !pause && (state_q == S_GAP);

    auto_player_gap_timer #(.W(GAP_W)) u_gap (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .run_i      (gap_run),
        .load_val_i (GAP_W'(GAP_CYCLES)),
        .expire_o   (gap_expire)
    );

    // next beats prev when both pulse together
    always_comb begin
        skip_song = song_q;
        to_done   = 1'b0;
        if (skip_next) begin
            if (song_q >= LAST_SONG) begin
                if (mode_norm(mode) == MODE_REPEAT_ALL)
                    skip_song = '0;
                else
                    to_done = 1'b1;
            end else begin
                skip_song = song_q + 1'b1;
            end
        end else if (song_q != '0) begin
            skip_song = song_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        song_d  = song_q;
        idx_d   = idx_q;
        note_d  = note_q;
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else if (skip) begin
            idx_d = '0;
            if (to_done) begin
                state_d = S_DONE;
            end else begin
                song_d = skip_song;
                if (pausable) begin
                    state_d = S_PAUSED;
                    saved_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    song_d  = (song > LAST_SONG) ? LAST_SONG : song;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    note_d  = rom_note;
                    state_d = S_PLAY;
                end
                // A note ending in the same cycle as pause resumes into its gap.
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                        saved_d = snd_over ? OVER_STATE : S_PLAY;
                    end else if (snd_over) begin
                        state_d = OVER_STATE;
                    end
                end
                S_GAP: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                        saved_d = S_GAP;
                    end else if (gap_expire) begin
                        state_d = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (idx_q < rom_track) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        idx_d = '0;
                        case (mode_norm(mode))
                            MODE_REPEAT_ONE: state_d = S_FETCH;
                            MODE_REPEAT_ALL: begin
                                song_d  = (song_q >= LAST_SONG) ? '0 : song_q + 1'b1;
                                state_d = S_FETCH;
                            end
                            default: state_d = S_DONE;
                        endcase
                    end
                end
                S_PAUSED: begin
                    if (!pause)
                        state_d = saved_q;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            saved_q <= S_PLAY;
            song_q  <= '0;
            idx_q   <= '0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
        end
    end

    // Note n (1-based, 0 = rest) lights key (n-1) mod NOTE_KEY_BITS.
    always_comb begin
        led = '0;
        if (state_q == S_PLAY && note_q != '0) begin
            for (int k = 0; k < NOTE_KEY_BITS; k++)
                led[k] = (((int'(note_q) - 1) % NOTE_KEY_BITS) == k);
        end
    end

    assign rom_song = song_q;
    assign rom_idx  = idx_q;
    assign snd_en   = (state_q == S_PLAY);
    assign playing  = (state_q == S_FETCH) || (state_q == S_PLAY) || (state_q == S_GAP);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player with a ROM and Sound model; expected (song, idx, led) per
// note start are queued as stimulus is driven and popped on every snd_en rising edge.
module tb_auto_player;
    import auto_player_pkg::*;

    localparam int GAP = 4;
    localparam int LEN = 16;

    logic       clk = 1'b0;
    logic       rst, en, pause, skip_next, skip_prev;
    logic [2:0] song;
    logic [1:0] mode;
    logic [2:0] rom_song;
    logic [7:0] rom_idx, rom_track;
    logic [NOTE_BITS-1:0] rom_note;
    logic       snd_en, snd_over, playing, done;
    logic [6:0] led;

    typedef struct {int s; int i;} exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   snd_cnt = 0;
    logic snd_en_prev = 1'b0;

    always #5 clk = ~clk;

    auto_player #(
        .NUM_SONGS(4), .SONG_BITS(3), .CNT_BITS(8), .NOTE_KEY_BITS(7), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .song(song), .mode(mode), .pause(pause),
        .skip_next(skip_next), .skip_prev(skip_prev), .rom_song(rom_song), .rom_idx(rom_idx),
        .rom_track(rom_track), .rom_note(rom_note), .snd_en(snd_en), .snd_over(snd_over),
        .led(led), .playing(playing), .done(done)
    );

    // ROM: last-index table per song, note = ((3*song + idx) mod 7) + 1
    always_comb begin
        case (rom_song)
            3'd0:    rom_track = 8'd2;
            3'd1:    rom_track = 8'd1;
            3'd2:    rom_track = 8'd2;
            default: rom_track = 8'd0;
        endcase
        rom_note = NOTE_BITS'(((int'(rom_song) * 3 + int'(rom_idx)) % 7) + 1);
    end

    // Sound: LEN enabled cycles per note, holds while disabled, clears on a fresh fetch
    assign snd_over = snd_en && (snd_cnt == LEN - 1);
    always @(posedge clk) begin
        if (rst || (playing && !snd_en) || snd_over)
            snd_cnt <= 0;
        else if (snd_en)
            snd_cnt <= snd_cnt + 1;
    end

    function automatic logic [6:0] exp_led(input int s, input int i);
        logic [6:0] one = 7'd1;
        return one << ((s * 3 + i) % 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && snd_en && !snd_en_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_note", {rom_song, rom_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_song", rom_song, e.s);
                check("sb_idx", rom_idx, e.i);
                check("sb_led", led, exp_led(e.s, e.i));
            end
        end
        snd_en_prev = snd_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!snd_en && n < 200);
        check(tag, snd_en, 1);
    endtask

    task automatic wait_over(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!snd_over && n < 200);
        check(tag, snd_over, 1);
    endtask

    // Silent cycles after snd_over until the next note or DONE; ADVANCE and FETCH add 2 to GAP.
    task automatic measure_gap(input string tag, input int exp_len);
        int   n   = 0;
        logic bad = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (snd_en || done) break;
            n++;
            if (led != '0) bad = 1'b1;
        end
        check(tag, n, exp_len);
        check({tag, "_led"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   play_cnt;
        int   n;
        logic bad;
        rst = 1'b1; en = 1'b0; song = 3'd0; mode = 2'd0;
        pause = 1'b0; skip_next = 1'b0; skip_prev = 1'b0;
        tick(3);
        check("rst_song", rom_song, 0);
        check("rst_idx", rom_idx, 0);
        check("rst_snd_en", snd_en, 0);
        check("rst_led", led, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);

        // once mode over song 0 (three notes)
        rst = 1'b0; en = 1'b1; mode = MODE_ONCE; song = 3'd0;
        exp_q.push_back('{0, 0}); exp_q.push_back('{0, 1}); exp_q.push_back('{0, 2});
        wait_play("once_start");
        wait_over("once_over0");
        measure_gap("once_gap0", GAP + 2);
        wait_over("once_over1");
        measure_gap("once_gap1", GAP + 2);
        wait_over("once_over2");
        measure_gap("once_gap2", GAP + 1);
        check("once_done", done, 1);
        check("once_playing", playing, 0);
        check("once_snd_en", snd_en, 0);

        // repeat-all wraps from the last song to song 0
        en = 1'b0; tick(1);
        check("idle_playing", playing, 0);
        check("idle_done", done, 0);
        mode = MODE_REPEAT_ALL; song = 3'd3; en = 1'b1;
        exp_q.push_back('{3, 0}); exp_q.push_back('{0, 0});
        wait_play("ra_start");
        wait_over("ra_over");
        wait_play("ra_wrap");
        check("ra_song", rom_song, 0);
        check("ra_idx", rom_idx, 0);
        check("ra_playing", playing, 1);

        // pause 10 cycles into a note, hold 50, resume without restart
        en = 1'b0; tick(1);
        song = 3'd0; en = 1'b1;
        exp_q.push_back('{0, 0});
        wait_play("pz_start");
        play_cnt = 1;
        repeat (9) begin @(negedge clk); if (snd_en) play_cnt++; end
        pause = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (snd_en || led != '0 || playing) bad = 1'b1;
        end
        check("pz_quiet", bad, 0);
        exp_q.push_back('{0, 0});
        pause = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (snd_en) play_cnt++;
        end while (!snd_over && n < 200);
        check("pz_note_len", play_cnt, LEN);

        // skip_prev while paused on song 0 restarts song 0 and stays paused
        exp_q.push_back('{0, 1});
        wait_play("pz_next_note");
        pause = 1'b1; tick(2);
        skip_prev = 1'b1; tick(1); skip_prev = 1'b0;
        check("pzsk_song", rom_song, 0);
        check("pzsk_idx", rom_idx, 0);
        check("pzsk_playing", playing, 0);
        tick(5);
        check("pzsk_snd_en", snd_en, 0);
        check("pzsk_done", done, 0);
        exp_q.push_back('{0, 0});
        pause = 1'b0;
        wait_play("pzsk_resume");

        // both skips together on song 1: next wins
        en = 1'b0; tick(1);
        song = 3'd1; en = 1'b1;
        exp_q.push_back('{1, 0});
        wait_play("sk_start");
        skip_next = 1'b1; skip_prev = 1'b1;
        exp_q.push_back('{2, 0});
        tick(1);
        skip_next = 1'b0; skip_prev = 1'b0;
        check("sk_both_song", rom_song, 2);
        check("sk_both_idx", rom_idx, 0);
        wait_play("sk_both_play");

        // skip_next in the snd_over cycle: song advance only
        wait_over("sk_over");
        skip_next = 1'b1;
        exp_q.push_back('{3, 0});
        tick(1);
        skip_next = 1'b0;
        check("sk_over_song", rom_song, 3);
        check("sk_over_idx", rom_idx, 0);
        wait_play("sk_over_play");

        // en dropped during GAP with rom_idx=1, then out-of-range song clamps
        en = 1'b0; tick(1);
        song = 3'd2; en = 1'b1;
        exp_q.push_back('{2, 0}); exp_q.push_back('{2, 1});
        wait_play("en_n0");
        wait_over("en_over0");
        wait_play("en_n1");
        wait_over("en_over1");
        tick(1);
        en = 1'b0; tick(1);
        check("en_playing", playing, 0);
        check("en_snd_en", snd_en, 0);
        check("en_idx", rom_idx, 0);
        song = 3'd7; en = 1'b1;
        exp_q.push_back('{3, 0});
        tick(1);
        check("clamp_song", rom_song, 3);
        wait_play("clamp_play");

        // once mode: skip_next on last song -> DONE; skip_prev from DONE restarts
        mode = MODE_ONCE;
        skip_next = 1'b1; tick(1); skip_next = 1'b0;
        check("skd_done", done, 1);
        check("skd_song", rom_song, 3);
        check("skd_playing", playing, 0);
        skip_prev = 1'b1;
        exp_q.push_back('{2, 0});
        tick(1);
        skip_prev = 1'b0;
        check("skd_prev_song", rom_song, 2);
        check("skd_prev_playing", playing, 1);
        check("skd_prev_done", done, 0);
        wait_play("skd_prev_play");

        // reset mid-PLAY, release with en=1 and song=2
        tick(3);
        rst = 1'b1; tick(3);
        check("rst2_song", rom_song, 0);
        check("rst2_idx", rom_idx, 0);
        check("rst2_snd_en", snd_en, 0);
        check("rst2_led", led, 0);
        check("rst2_playing", playing, 0);
        check("rst2_done", done, 0);
        song = 3'd2;
        exp_q.push_back('{2, 0});
        rst = 1'b0;
        tick(2);
        check("rel_song", rom_song, 2);
        check("rel_idx", rom_idx, 0);
        check("rel_snd_en", snd_en, 1);

        tick(2);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
